irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller on a Bridge device slot, between the peripheral interrupt sources (TC.IRQ, MiniUART.Interrupt, Key, ...) and the CPU HWInt[5:0] input.
- Synchronizes raw sources and latches edge events into pending bits.
- Applies a software mask, resolves a fixed priority, and drives a registered, masked interrupt vector plus a claim/complete handshake, so the exception handler services one source at a time.

Parameters:
- N_SRC, 6, number of interrupt sources (1..6). Maps 1:1 onto HWInt bits.
- SYNC_STAGES, 2, synchronizer flops per source (minimum 2).

Ports:
- clk  input  1  system clock (CLK_OUT1 domain)
- reset  input  1  asynchronous, active-high reset
- Addr  input  3  word offset within the device window (DEVAddr[4:2])
- WE  input  1  register write strobe from Bridge
- Din  input  32  write data (DEVWD)
- Dout  output  32  read data, combinational from Addr
- src_irq  input  N_SRC  raw source lines; may be asynchronous
- HWInt  output  6  registered (pending & mask) to CPU; bits >= N_SRC are 0
- irq_any  output  1  registered OR of HWInt

Behaviour:
- Reset: asynchronous, active-high. Clears every flop: sync chains, prev, PEND, MASK, EDGE, INSVC, HWInt, irq_any. All outputs are 0 during and after reset until software writes MASK.
- Register map (word offset):
  - 0 PEND: read; write-1-to-clear.
  - 1 MASK: read/write, 1 = enabled.
  - 2 EDGE: read/write, 1 = rising-edge latched, 0 = level.
  - 3 CLAIM: read returns {valid, 23'b0, id[7:0]}. id is the lowest index with PEND & MASK & ~INSVC; valid=0 and id=0 if none. Read is side-effect-free.
  - 4 COMPLETE: write Din[7:0]=id clears INSVC[id]. Out-of-range id is ignored.
  - 5 INSVC: read; write 1 to bit i sets INSVC[i] (software claim). Writing 0 has no effect.
  - 6, 7: read 0, writes ignored.
- Write-data width: only bits [N_SRC-1:0] of Din are used for PEND/MASK/EDGE/INSVC. Upper bits read back 0.
- Synchronization: s = SYNC_STAGES-flop chain per source; prev = s delayed one cycle.
- Edge mode: PEND[i] sets on the cycle s[i]&~prev[i]; it stays set until a W1C write. A set and a clear of the same bit in one cycle: set wins.
- Level mode: PEND[i] = s[i] each cycle. W1C writes have no lasting effect.
- Mode change: writing EDGE 0->1 or 1->0 clears PEND[i] in that cycle.
- HWInt[i] <= PEND[i] & MASK[i] & ~INSVC[i], registered. irq_any <= |that.
- Latency: src rising edge sampled at clk edge k -> PEND set at edge k+SYNC_STAGES -> HWInt high after edge k+SYNC_STAGES+1. For the default this is 3 cycles.
- Register-write latency: a MASK or INSVC write at edge k affects HWInt after edge k+1.
- Pulses shorter than one clk period may be lost; sources are required to hold for at least 2 cycles.
- Priority: fixed, index 0 highest (timer). No preemption logic inside the block; nesting is managed by software via INSVC.
- Bridge contract: WE is a single-cycle strobe. Dout is valid in the same cycle as Addr, with no wait states.

Decomposition:
- Shared package irq_pkg:
  - register offset constants (IRQ_PEND=0 ... IRQ_INSVC=5)
  - N_SRC_MAX=6
  - CLAIM valid-bit position (31)
- Sub-module irq_sync_edge: one source's synchronizer, edge detector and PEND bit. Instantiated N_SRC times by a generate loop.
- The priority encoder stays inline as a function.

Test Plan:
- Reset then idle: reset high mid-run with PEND=6'h3F, MASK=6'h3F -> all state and HWInt=0 immediately (asynchronous), and still 0 after reset is released.
- Edge latency: MASK=6'h01, EDGE=6'h01, src_irq[0] pulsed for 2 cycles at edge k -> HWInt=6'h01 after edge k+3. It holds after the source drops until a write of PEND=1, then HWInt=0 one cycle later.
- Priority/claim: EDGE=6'h3F, MASK=6'h3F, sources 2 and 4 fire -> CLAIM reads 32'h8000_0002. Write INSVC=6'h04 -> CLAIM reads 32'h8000_0004 and HWInt=6'h10. Write COMPLETE=2 -> HWInt=6'h14.
- Set/clear collision: edge on src 1 in the same cycle as a W1C write of PEND=6'h02 -> PEND reads 6'h02 afterwards.
- Level mode: EDGE=0, MASK=6'h08, src_irq[3] held high -> HWInt[3]=1 three cycles later. A W1C write does not clear it. The source goes low -> HWInt[3]=0 three cycles later.
- Mask gating: PEND=6'h20 with MASK=0 -> HWInt=0 and CLAIM=0. Write MASK=6'h20 -> HWInt=6'h20 after one edge; irq_any=1.

Source files
------------

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Definitions shared by the interrupt controller files.
//   N_SRC_MAX       : widest source count supported (one per CPU HWInt bit)
//   CLAIM_VALID_BIT : bit position of the valid flag in the CLAIM read word
//   CLAIM_ID_W      : width of the source id field in CLAIM/COMPLETE
//   irq_reg_e       : word offsets of the registers within the device window
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int unsigned N_SRC_MAX       = 6;
    localparam int unsigned CLAIM_VALID_BIT = 31;
    localparam int unsigned CLAIM_ID_W      = 8;

    typedef enum logic [2:0] {
        IRQ_PEND     = 3'd0,
        IRQ_MASK     = 3'd1,
        IRQ_EDGE     = 3'd2,
        IRQ_CLAIM    = 3'd3,
        IRQ_COMPLETE = 3'd4,
        IRQ_INSVC    = 3'd5
    } irq_reg_e;

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// One interrupt source: multi-flop synchronizer, rising-edge detector and the
// PEND bit for that source.
//   clk, reset : system clock, asynchronous active-high reset
//   src        : raw (possibly asynchronous) interrupt line
//   edge_mode  : 1 = latch rising edges, 0 = follow the synchronized level
//   mode_chg   : EDGE bit is being flipped this cycle; clears PEND
//   w1c        : write-1-to-clear strobe for PEND (edge mode only)
//   pend       : pending bit
// -----------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic edge_mode,
    input  logic mode_chg,
    input  logic w1c,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            prev_q <= s;
        end
    end

    // Mode change dominates; in edge mode a new edge beats a simultaneous
    // W1C so an event arriving during the clear is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (mode_chg) begin
            pend <= 1'b0;
        end else if (edge_mode) begin
            if (rise) begin
                pend <= 1'b1;
            end else if (w1c) begin
                pend <= 1'b0;
            end
        end else begin
            pend <= s;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Memory-mapped interrupt controller on a Bridge device slot. Synchronizes the
// peripheral interrupt lines, latches them into PEND, masks them, and drives a
// registered interrupt vector to the CPU plus a CLAIM/COMPLETE handshake that
// lets the handler service one source at a time (fixed priority, index 0 high).
//   clk, reset : system clock, asynchronous active-high reset
//   Addr       : word offset within the device window
//   WE         : single-cycle register write strobe
//   Din        : write data
//   Dout       : read data, combinational from Addr
//   src_irq    : raw interrupt source lines
//   HWInt      : registered PEND & MASK & ~INSVC; bits >= N_SRC are 0
//   irq_any    : registered OR of HWInt
// Register map: 0 PEND (W1C), 1 MASK, 2 EDGE, 3 CLAIM (RO), 4 COMPLETE (WO),
// 5 INSVC (write-1-to-set), 6/7 reserved (read 0).
// -----------------------------------------------------------------------------
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC       = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] src_irq,
    output logic [5:0]       HWInt,
    output logic             irq_any
);

    logic [N_SRC-1:0]     pend;
    logic [N_SRC-1:0]     mask_q;
    logic [N_SRC-1:0]     edge_q;
    logic [N_SRC-1:0]     insvc_q;
    logic [N_SRC-1:0]     active;
    logic [N_SRC-1:0]     w1c;
    logic [N_SRC-1:0]     mode_chg;
    logic [N_SRC-1:0]     wr_bits;
    logic [N_SRC_MAX-1:0] hw_next;
    logic [31:0]          claim_word;
    logic [CLAIM_ID_W-1:0] cpl_id;

    logic wr_pend;
    logic wr_mask;
    logic wr_edge;
    logic wr_complete;
    logic wr_insvc;

    // Only the id field and the per-source bits of Din are meaningful.
    logic unused_din;
    assign unused_din = &{1'b0, Din[31:CLAIM_ID_W]};

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_pend     = WE && (Addr == IRQ_PEND);
    assign wr_mask     = WE && (Addr == IRQ_MASK);
    assign wr_edge     = WE && (Addr == IRQ_EDGE);
    assign wr_complete = WE && (Addr == IRQ_COMPLETE);
    assign wr_insvc    = WE && (Addr == IRQ_INSVC);

    assign wr_bits  = Din[N_SRC-1:0];
    assign cpl_id   = Din[CLAIM_ID_W-1:0];
    assign w1c      = wr_pend ? wr_bits : '0;
    assign mode_chg = wr_edge ? (wr_bits ^ edge_q) : '0;

    // ------------------------------------------------------------------
    // Per-source synchronizer / edge detector / PEND
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk       (clk),
            .reset     (reset),
            .src       (src_irq[i]),
            .edge_mode (edge_q[i]),
            .mode_chg  (mode_chg[i]),
            .w1c       (w1c[i]),
            .pend      (pend[i])
        );
    end

    // ------------------------------------------------------------------
    // MASK / EDGE / INSVC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (wr_mask) begin
            mask_q <= wr_bits;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
        end else if (wr_edge) begin
            edge_q <= wr_bits;
        end
    end

    // INSVC is set by software claim and cleared by COMPLETE; an id outside
    // the implemented sources matches no bit and is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insvc_q <= '0;
        end else if (wr_insvc) begin
            insvc_q <= insvc_q | wr_bits;
        end else if (wr_complete) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (cpl_id == CLAIM_ID_W'(i)) begin
                    insvc_q[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Priority resolution and outputs
    // ------------------------------------------------------------------
    assign active = pend & mask_q & ~insvc_q;

    // Lowest set index wins; 0 when nothing is set.
    function automatic logic [CLAIM_ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [CLAIM_ID_W-1:0] id;
        logic                  found;
        id    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (v[i] && !found) begin
                id    = CLAIM_ID_W'(i);
                found = 1'b1;
            end
        end
        return id;
    endfunction

    always_comb begin
        claim_word                   = '0;
        claim_word[CLAIM_VALID_BIT]  = |active;
        claim_word[CLAIM_ID_W-1:0]   = lowest_set(active);
    end

    always_comb begin
        hw_next              = '0;
        hw_next[N_SRC-1:0]   = active;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HWInt   <= '0;
            irq_any <= 1'b0;
        end else begin
            HWInt   <= hw_next;
            irq_any <= |hw_next;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        Dout = '0;
        case (Addr)
            IRQ_PEND:  Dout[N_SRC-1:0] = pend;
            IRQ_MASK:  Dout[N_SRC-1:0] = mask_q;
            IRQ_EDGE:  Dout[N_SRC-1:0] = edge_q;
            IRQ_CLAIM: Dout            = claim_word;
            IRQ_INSVC: Dout[N_SRC-1:0] = insvc_q;
            default:   Dout            = '0;
        endcase
    end

endmodule
